// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column widths, engine FSM states and the
// GF(2^8) helpers used by the column transform.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant, which covers every MixColumns coefficient.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

endpackage

// File: rtl/mixcolumn_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column.
// Row 0 sits in the most significant byte.
module mixcolumn_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    input  logic             inv,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] s [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            s[r] = col_in[COL_W-1-8*r -: 8];
        end
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                col_out[COL_W-1-8*r -: 8] = gf_mul_const(s[r], 4'he)
                                          ^ gf_mul_const(s[(r+1)%4], 4'hb)
                                          ^ gf_mul_const(s[(r+2)%4], 4'hd)
                                          ^ gf_mul_const(s[(r+3)%4], 4'h9);
            end else begin
                col_out[COL_W-1-8*r -: 8] = gf_mul_const(s[r], 4'h2)
                                          ^ gf_mul_const(s[(r+1)%4], 4'h3)
                                          ^ s[(r+2)%4]
                                          ^ s[(r+3)%4];
            end
        end
    end

endmodule

// File: rtl/mixcolumn_engine.sv
// Iterative MixColumns engine: transforms COLS_PER_CYCLE columns of a latched
// AES state per clock, then holds the result until the consumer takes it.
module mixcolumn_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic               inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its data stable while valid waits for ready.

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mixcolumn_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] CNT_LAST = 2'((4 - COLS_PER_CYCLE) % 4);

    state_t             state;
    state_t             next_state;
    logic [1:0]         cnt;
    logic               mode;
    logic [STATE_W-1:0] work;
    logic [STATE_W-1:0] next_work;
    logic [COL_W-1:0]   lane_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0]   lane_out [COLS_PER_CYCLE];

    function automatic int col_msb(input int c);
        return STATE_W - 1 - COL_W * (c % 4);
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = RUN;
            RUN:  if (cnt == CNT_LAST) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lanes always cover columns cnt.. cnt+COLS_PER_CYCLE-1; cnt is a multiple
    // of COLS_PER_CYCLE so a lane group never wraps past column 3.
    always_comb begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            lane_in[i] = work[col_msb(int'(cnt) + i) -: COL_W];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
            mixcolumn_column u_column (
                .col_in  (lane_in[g]),
                .inv     (mode),
                .col_out (lane_out[g])
            );
        end
    endgenerate

    always_comb begin
        next_work = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            next_work[col_msb(int'(cnt) + i) -: COL_W] = lane_out[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            mode <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= state_in;
                        mode <= inv;
                        cnt  <= 2'd0;
                    end
                end
                RUN: begin
                    work <= next_work;
                    cnt  <= cnt + CNT_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumn_engine.sv
// Bench for mixcolumn_engine: three instances (1, 2 and 4 columns per cycle)
// share one stimulus stream; a scoreboard per instance checks every result.
module tb_mixcolumn_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic         inv;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   out_ready_v;
    logic [2:0]   busy_v;
    logic [127:0] state_out_v [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];
    logic [127:0] exp_q2[$];

    logic         bp_mode;
    logic [2:0]   ready_force;
    logic [2:0]   prev_stall;
    logic [2:0]   was_valid;
    logic [127:0] prev_out [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mixcolumn_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_v[g]),
                .state_in  (state_in),
                .inv       (inv),
                .out_valid (out_valid_v[g]),
                .out_ready (out_ready_v[g]),
                .state_out (state_out_v[g]),
                .busy      (busy_v[g])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int bitn = 15; bitn >= 8; bitn--) if (p[bitn]) p = p ^ (16'h11b << (bitn - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic m);
        logic [7:0]   b [16];
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (m) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int j = 0; j < 16; j++) b[j] = s[127-8*j -: 8];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[k], b[4*c + (row + k) % 4]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [127:0] e);
        exp_q0.push_back(e);
        exp_q1.push_back(e);
        exp_q2.push_back(e);
    endfunction

    function automatic void pop_check(input int g, input logic [127:0] act);
        logic [127:0] e;
        int sz;
        sz = (g == 0) ? exp_q0.size() : (g == 1) ? exp_q1.size() : exp_q2.size();
        checks++;
        if (sz == 0) begin
            failures++;
            $display("FAIL unexpected_out dut%0d got=%h exp=none", g, act);
        end else begin
            case (g)
                0: e = exp_q0.pop_front();
                1: e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            if (act !== e) begin
                failures++;
                $display("FAIL result dut%0d got=%h exp=%h", g, act, e);
            end
        end
    endfunction

    // ---------------- consumer ----------------
    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 3; g++) begin
            out_ready_v[g] = bp_mode ? 1'($urandom_range(0, 1)) : ready_force[g];
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = '0;
            was_valid  = '0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("in_ready_vs_busy dut%0d", g), 128'(in_ready_v[g]), 128'(!busy_v[g]));
                if (prev_stall[g]) begin
                    check($sformatf("hold_valid dut%0d", g), 128'(out_valid_v[g]), 128'(1'b1));
                    check($sformatf("hold_data dut%0d", g), state_out_v[g], prev_out[g]);
                end
                if (out_valid_v[g] && !was_valid[g]) begin
                    check($sformatf("latency dut%0d", g), 128'(cyc - acc_cyc), 128'(4 >> g));
                end
                if (out_valid_v[g] && out_ready_v[g]) pop_check(g, state_out_v[g]);
                prev_stall[g] = out_valid_v[g] && !out_ready_v[g];
                prev_out[g]   = state_out_v[g];
                was_valid[g]  = out_valid_v[g];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [127:0] s, input logic m, input logic [127:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready_v != 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready_v != 3'b111) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=%b exp=111", in_ready_v);
            return;
        end
        in_valid = 1'b1;
        state_in = s;
        inv      = m;
        push_exp(e);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        inv      = ~m;
        check("ready_low_after_accept", 128'(in_ready_v), 128'(3'b000));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size() != 0 || in_ready_v != 3'b111) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q0.size() + exp_q1.size() + exp_q2.size());
        end
    endtask

    localparam logic [127:0] V_A  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V_AF = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] V_B  = 128'hd4d4d4d52d26314c00000000ffffffff;
    localparam logic [127:0] V_BF = 128'hd5d5d7d64d7ebdf800000000ffffffff;

    initial begin
        logic [127:0] s;
        rst         = 1'b1;
        in_valid    = 1'b0;
        state_in    = '0;
        inv         = 1'b0;
        bp_mode     = 1'b0;
        ready_force = 3'b111;
        out_ready_v = 3'b111;
        prev_stall  = '0;
        was_valid   = '0;

        // reset state
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_in_ready dut%0d", g), 128'(in_ready_v[g]), 128'(1'b0));
            check($sformatf("rst_out_valid dut%0d", g), 128'(out_valid_v[g]), 128'(1'b0));
            check($sformatf("rst_busy dut%0d", g), 128'(busy_v[g]), 128'(1'b0));
            check($sformatf("rst_state_out dut%0d", g), state_out_v[g], 128'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 128'(in_ready_v), 128'(3'b111));

        // known-answer vectors, both directions
        send(V_A, 1'b0, V_AF);
        send(V_AF, 1'b1, V_A);
        send(V_B, 1'b0, V_BF);
        send(V_BF, 1'b1, V_B);
        wait_idle();

        // backpressure: results held, new requests ignored
        ready_force = 3'b000;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b1, mix_ref(s, 1'b1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = i[0];
            state_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("bp_in_ready", 128'(in_ready_v), 128'(3'b000));
        end
        in_valid    = 1'b0;
        ready_force = 3'b111;
        wait_idle();

        // reset in the middle of an operation
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, mix_ref(s, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_out_valid", 128'(out_valid_v), 128'(3'b000));
        check("midrun_in_ready", 128'(in_ready_v), 128'(3'b000));
        check("midrun_busy", 128'(busy_v), 128'(3'b000));
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_midrun_reset", 128'(in_ready_v), 128'(3'b111));
        send(V_A, 1'b0, V_AF);
        wait_idle();

        // random regression under random backpressure
        bp_mode = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                send(s, 1'(m), mix_ref(s, 1'(m)));
            end
        end
        wait_idle();
        bp_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
